// File: rtl/jtkiwi_obj_linebuf.sv
// Double-buffered object line buffer: the drawer fills one bank while the other
// is scanned out and erased behind the beam. A clear sequencer wipes both banks at power-up.
module jtkiwi_obj_linebuf #(
  parameter int unsigned AW      = 9,
  parameter int unsigned DW      = 9,
  parameter int unsigned HOFFSET = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [AW-1:0] hdump,
  output logic          draw_start,
  input  logic          draw_done,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_we,
  output logic [DW-1:0] obj_pxl,
  output logic [7:0]    overrun,
  output logic          ready
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_addr;
  logic          bank_sel;
  logic          busy;
  logic          lhbl_l;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] rd_dout;

  // Pending load of obj_pxl and pending erase, both latched on the read clk
  logic          ld_pend;
  logic          ld_blank;
  logic          er_pend;
  logic          er_bank;
  logic [AW-1:0] er_addr;

  logic          run_c;
  logic          swap_c;
  logic          scan_c;
  logic          blank_c;
  logic          wr_ok_c;
  logic [AW-1:0] rd_addr_c;

  always_comb begin
    run_c     = (state == RUN);
    swap_c    = run_c & lhbl_l & ~LHBL;
    scan_c    = run_c & pxl_cen & LHBL;
    blank_c   = run_c & pxl_cen & ~LHBL;
    wr_ok_c   = run_c & wr_we & (wr_data[3:0] != 4'd0);
    rd_addr_c = hdump + AW'(HOFFSET);
  end

  // Control: clear sequencing, bank swap, busy/overrun tracking, pixel output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      bank_sel   <= 1'b0;
      busy       <= 1'b0;
      lhbl_l     <= 1'b0;
      draw_start <= 1'b0;
      overrun    <= 8'd0;
      ready      <= 1'b0;
      obj_pxl    <= '0;
      ld_pend    <= 1'b0;
      ld_blank   <= 1'b0;
      er_pend    <= 1'b0;
      er_bank    <= 1'b0;
      er_addr    <= '0;
    end else begin
      lhbl_l <= LHBL;
      case (state)
        CLEAR: begin
          clr_addr   <= clr_addr + AW'(1);
          draw_start <= 1'b0;
          obj_pxl    <= '0;
          ld_pend    <= 1'b0;
          er_pend    <= 1'b0;
          if (clr_addr == AW'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          draw_start <= swap_c;
          if (swap_c) begin
            bank_sel <= ~bank_sel;
            busy     <= 1'b1;
            if (busy && !draw_done && overrun != 8'hFF)
              overrun <= overrun + 8'd1;
          end else if (draw_done) begin
            busy <= 1'b0;
          end

          ld_pend  <= scan_c | blank_c;
          ld_blank <= blank_c;
          er_pend  <= scan_c;
          if (scan_c) begin
            er_addr <= rd_addr_c;
            er_bank <= bank_sel;
          end
          if (ld_pend)
            obj_pxl <= ld_blank ? '0 : rd_dout;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Bank storage: clear both, erase behind the read, drawer writes win on a collision
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem0[clr_addr] <= '0;
      mem1[clr_addr] <= '0;
    end else begin
      if (er_pend) begin
        if (er_bank) mem1[er_addr] <= '0;
        else         mem0[er_addr] <= '0;
      end
      if (wr_ok_c) begin
        if (bank_sel) mem0[wr_addr] <= wr_data;
        else          mem1[wr_addr] <= wr_data;
      end
      if (scan_c)
        rd_dout <= bank_sel ? mem1[rd_addr_c] : mem0[rd_addr_c];
    end
  end

endmodule

// File: tb/tb_jtkiwi_obj_linebuf.sv
// Directed bench for the object line buffer: clear, draw/scan/erase, transparency,
// overrun counting and saturation, read-address offset wrap and mid-line reset.
module tb_jtkiwi_obj_linebuf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b1;
  logic [8:0] hdump = '0;
  logic       draw_done = 1'b0;
  logic [8:0] wr_addr = '0;
  logic [8:0] wr_data = '0;
  logic       wr_we = 1'b0;

  logic       draw_start, draw_start2;
  logic [8:0] obj_pxl, obj_pxl2;
  logic [7:0] overrun, overrun2;
  logic       ready, ready2;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [8:0] hd;
    logic [8:0] exp;
  } vec_t;

  vec_t vec [9];

  jtkiwi_obj_linebuf #(.AW(9), .DW(9), .HOFFSET(0)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .hdump(hdump),
    .draw_start(draw_start), .draw_done(draw_done), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_we(wr_we), .obj_pxl(obj_pxl), .overrun(overrun),
    .ready(ready)
  );

  jtkiwi_obj_linebuf #(.AW(9), .DW(9), .HOFFSET(8)) dut_off (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .hdump(hdump),
    .draw_start(draw_start2), .draw_done(draw_done), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_we(wr_we), .obj_pxl(obj_pxl2), .overrun(overrun2),
    .ready(ready2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [8:0] d);
    wr_we = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_we = 1'b0;
  endtask

  task automatic done_pulse();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
  endtask

  // One pxl_cen during active video, then one more clk so obj_pxl is loaded
  task automatic scan(input logic [8:0] hd);
    LHBL = 1'b1; hdump = hd; pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    tick();
  endtask

  // LHBL falling edge; optional draw_done on the swap clk and pxl_cen during blank
  task automatic do_swap(input logic done_same, input logic cen);
    LHBL = 1'b0; draw_done = done_same; pxl_cen = cen;
    tick();
    draw_done = 1'b0; pxl_cen = 1'b0;
    chk("draw_start_pulse", 16'(draw_start), 16'd1);
    tick();
    if (cen) chk("blank_load_zero", 16'(obj_pxl), 16'd0);
    LHBL = 1'b1;
    tick();
  endtask

  task automatic run_clear(input logic toggle_lhbl);
    logic seen;
    seen = 1'b0;
    for (int k = 1; k <= 512; k++) begin
      if (toggle_lhbl) LHBL = ((k % 64) < 32);
      tick();
      if (draw_start) seen = 1'b1;
      if (k == 511) chk("ready_low_511", 16'(ready), 16'd0);
      if (k == 512) chk("ready_high_512", 16'(ready), 16'd1);
    end
    LHBL = 1'b1;
    chk("no_draw_start_in_clear", 16'(seen), 16'd0);
    tick();
  endtask

  initial begin
    vec[0] = '{9'd10,  9'h1A5};
    vec[1] = '{9'd11,  9'h000};
    vec[2] = '{9'd9,   9'h000};
    vec[3] = '{9'd20,  9'h123};
    vec[4] = '{9'd30,  9'h067};
    vec[5] = '{9'd30,  9'h000};
    vec[6] = '{9'd0,   9'h000};
    vec[7] = '{9'd511, 9'h000};
    vec[8] = '{9'd50,  9'h1FF};

    #3 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_obj_pxl", 16'(obj_pxl), 16'd0);
    chk("rst_ready", 16'(ready), 16'd0);
    chk("rst_overrun", 16'(overrun), 16'd0);
    chk("rst_draw_start", 16'(draw_start), 16'd0);
    rst_n = 1'b1;

    run_clear(1'b0);
    chk("ready_off_inst", 16'(ready2), 16'd1);

    scan(9'd10);
    chk("clear_bank0_x10", 16'(obj_pxl), 16'd0);
    scan(9'd511);
    chk("clear_bank0_x511", 16'(obj_pxl), 16'd0);

    // Swap 1: busy was clear, so no overrun
    do_swap(1'b0, 1'b0);
    chk("ovr_after_swap1", 16'(overrun), 16'd0);
    scan(9'd10);
    chk("clear_bank1_x10", 16'(obj_pxl), 16'd0);

    wr(9'd10, 9'h1A5);
    wr(9'd20, 9'h123);
    wr(9'd20, 9'h0F0);
    wr(9'd30, 9'h045);
    wr(9'd30, 9'h067);
    wr(9'd50, 9'h1FF);
    done_pulse();

    do_swap(1'b0, 1'b0);
    chk("ovr_after_swap2", 16'(overrun), 16'd0);

    for (int i = 0; i < 9; i++) begin
      scan(vec[i].hd);
      chk($sformatf("line_x%0d", vec[i].hd), 16'(obj_pxl), 16'(vec[i].exp));
    end

    // Swap 3 with a blank-time pxl_cen; busy still set from swap 2
    do_swap(1'b0, 1'b1);
    chk("ovr_after_swap3", 16'(overrun), 16'd1);
    do_swap(1'b0, 1'b0);
    chk("ovr_after_swap4", 16'(overrun), 16'd2);

    scan(9'd10);
    chk("erased_x10", 16'(obj_pxl), 16'd0);
    scan(9'd20);
    chk("erased_x20", 16'(obj_pxl), 16'd0);

    do_swap(1'b1, 1'b0);
    chk("ovr_done_same_clk", 16'(overrun), 16'd2);
    do_swap(1'b0, 1'b0);
    chk("ovr_busy_reset", 16'(overrun), 16'd3);

    for (int i = 0; i < 251; i++) do_swap(1'b0, 1'b0);
    chk("ovr_254", 16'(overrun), 16'd254);
    do_swap(1'b0, 1'b0);
    chk("ovr_255", 16'(overrun), 16'd255);
    for (int i = 0; i < 48; i++) do_swap(1'b0, 1'b0);
    chk("ovr_saturated", 16'(overrun), 16'd255);
    chk("ovr_saturated_off", 16'(overrun2), 16'd255);

    // Read address wraps: 507 + 8 = 3 (mod 512)
    wr(9'd3, 9'h1B7);
    done_pulse();
    do_swap(1'b0, 1'b0);
    chk("off_draw_start", 16'(draw_start2), 16'd0);
    scan(9'd507);
    chk("offset_wrap_pixel", 16'(obj_pxl2), 16'h1B7);
    chk("no_offset_x507", 16'(obj_pxl), 16'd0);

    do_swap(1'b0, 1'b0);
    wr(9'd40, 9'h1C9);
    do_swap(1'b0, 1'b0);
    scan(9'd40);
    chk("final_line_x40", 16'(obj_pxl), 16'h1C9);

    // Asynchronous reset in the middle of scan-out
    hdump = 9'd41; pxl_cen = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    pxl_cen = 1'b0;
    chk("midrst_obj_pxl", 16'(obj_pxl), 16'd0);
    chk("midrst_overrun", 16'(overrun), 16'd0);
    chk("midrst_ready", 16'(ready), 16'd0);
    tick();
    rst_n = 1'b1;
    run_clear(1'b1);
    do_swap(1'b0, 1'b0);
    chk("ovr_after_rerun", 16'(overrun), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
